// File: rtl/onn_phase_loader.sv
// onn_phase_loader
// ----------------
// Initialisation and convergence controller for the 3x5 ONN neuron array.
// After an accepted start it writes a captured initial-phase pattern into the
// neurons one per cycle, then lets the network oscillate. After each full_tick
// it strobes state_cheak and reads back the neurons' state_changed flags.
// It stops with converged once STABLE_TICKS consecutive checks report no
// change, or with timeout once MAX_TICKS full_ticks have been accepted.
//
// Ports
//   sclk          in   system clock, rising edge
//   re_n          in   asynchronous active-low reset
//   start         in   level; accepted only in IDLE or DONE
//   pattern       in   N*PW initial phases, neuron k = pattern[k*PW +: PW]
//   full_tick     in   one-cycle pulse at the end of an oscillation period
//   state_changed in   N per-neuron phase-changed flags
//   ini_phase     out  PW shared initial-phase bus
//   ren           out  N one-hot per-neuron write enable
//   drop          out  write strobe
//   state_cheak   out  one-cycle check strobe to all neurons
//   busy          out  high in LOAD, RUN, CHECK, SAMPLE
//   converged     out  sticky until next accepted start or reset
//   timeout       out  sticky until next accepted start or reset
//   tick_count    out  TW accepted full_ticks since last start (saturating)
//   dbg_state     out  current FSM state encoding, for observation only
//
// Write interface: a neuron k loads ini_phase on the rising edge where
// ren[k] & drop is high. There is no back-pressure; the neurons must accept
// one write per cycle. ren/drop are only ever high in LOAD.
//
// All outputs come straight from flops; every output value is computed from
// the next state in the combinational process and registered together.

module onn_phase_loader #(
    parameter int N            = 15,
    parameter int PW           = 4,
    parameter int STABLE_TICKS = 4,
    parameter int MAX_TICKS    = 200,
    parameter int TW           = 8
) (
    input  logic            sclk,
    input  logic            re_n,
    input  logic            start,
    input  logic [N*PW-1:0] pattern,
    input  logic            full_tick,
    input  logic [N-1:0]    state_changed,
    output logic [PW-1:0]   ini_phase,
    output logic [N-1:0]    ren,
    output logic            drop,
    output logic            state_cheak,
    output logic            busy,
    output logic            converged,
    output logic            timeout,
    output logic [TW-1:0]   tick_count,
    output logic [2:0]      dbg_state
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam logic [N-1:0] REN_LSB = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_CHECK  = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx, idx_inc;
    logic [SW-1:0]     stable_cnt, stable_nx, stable_inc, stable_new;
    logic [N*PW-1:0]   shadow, shadow_nx;

    logic [PW-1:0]     ini_nx;
    logic [N-1:0]      ren_nx;
    logic              drop_nx, cheak_nx, busy_nx, conv_nx, tmo_nx;
    logic [TW-1:0]     tick_nx;

    assign dbg_state = state;

    // State and output registers
    always_ff @(posedge sclk or negedge re_n) begin
        if (!re_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            stable_cnt  <= '0;
            shadow      <= '0;
            ini_phase   <= '0;
            ren         <= '0;
            drop        <= 1'b0;
            state_cheak <= 1'b0;
            busy        <= 1'b0;
            converged   <= 1'b0;
            timeout     <= 1'b0;
            tick_count  <= '0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            stable_cnt  <= stable_nx;
            shadow      <= shadow_nx;
            ini_phase   <= ini_nx;
            ren         <= ren_nx;
            drop        <= drop_nx;
            state_cheak <= cheak_nx;
            busy        <= busy_nx;
            converged   <= conv_nx;
            timeout     <= tmo_nx;
            tick_count  <= tick_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        stable_nx  = stable_cnt;
        shadow_nx  = shadow;
        ini_nx     = '0;
        ren_nx     = '0;
        drop_nx    = 1'b0;
        cheak_nx   = 1'b0;
        conv_nx    = converged;
        tmo_nx     = timeout;
        tick_nx    = tick_count;
        idx_inc    = idx + 1'b1;
        stable_inc = stable_cnt + 1'b1;
        stable_new = '0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    shadow_nx = pattern;
                    conv_nx   = 1'b0;
                    tmo_nx    = 1'b0;
                    tick_nx   = '0;
                    stable_nx = '0;
                    idx_nx    = '0;
                    state_nx  = S_LOAD;
                    // Neuron 0 is presented in the first LOAD cycle, so its
                    // phase comes from the live pattern being captured now.
                    ren_nx    = REN_LSB;
                    drop_nx   = 1'b1;
                    ini_nx    = pattern[PW-1:0];
                end
            end

            S_LOAD: begin
                if (idx == IW'(N - 1)) begin
                    idx_nx   = '0;
                    state_nx = S_RUN;
                end else begin
                    idx_nx  = idx_inc;
                    ren_nx  = REN_LSB << idx_inc;
                    drop_nx = 1'b1;
                    ini_nx  = shadow[idx_inc*PW +: PW];
                end
            end

            S_RUN: begin
                if (full_tick) begin
                    if (tick_count != {TW{1'b1}}) begin
                        tick_nx = tick_count + 1'b1;
                    end
                    cheak_nx = 1'b1;
                    state_nx = S_CHECK;
                end
            end

            S_CHECK: begin
                state_nx = S_SAMPLE;
            end

            S_SAMPLE: begin
                stable_new = (|state_changed) ? '0 : stable_inc;
                stable_nx  = stable_new;
                // Convergence is tested first so it wins a same-cycle tie.
                if (stable_new == SW'(STABLE_TICKS)) begin
                    conv_nx  = 1'b1;
                    state_nx = S_DONE;
                end else if (tick_count >= TW'(MAX_TICKS)) begin
                    tmo_nx   = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_RUN;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase

        busy_nx = (state_nx == S_LOAD) || (state_nx == S_RUN) ||
                  (state_nx == S_CHECK) || (state_nx == S_SAMPLE);
    end

endmodule

// File: tb/tb_onn_phase_loader.sv
// Bench for onn_phase_loader: load sequence scoreboard, table of run scenarios,
// and hand-written sequences for held full_tick and mid-LOAD reset.

module tb_onn_phase_loader;

    localparam int N  = 15;
    localparam int PW = 4;
    localparam int TW = 8;
    localparam int W  = N + PW;

    logic            sclk = 1'b0;
    logic            re_n = 1'b0;
    logic            start = 1'b0;
    logic [N*PW-1:0] pattern = '0;
    logic            full_tick = 1'b0;
    logic [N-1:0]    state_changed = '0;
    logic [PW-1:0]   ini_phase;
    logic [N-1:0]    ren;
    logic            drop;
    logic            state_cheak;
    logic            busy;
    logic            converged;
    logic            timeout;
    logic [TW-1:0]   tick_count;
    logic [2:0]      dbg_state;

    onn_phase_loader dut (
        .sclk          (sclk),
        .re_n          (re_n),
        .start         (start),
        .pattern       (pattern),
        .full_tick     (full_tick),
        .state_changed (state_changed),
        .ini_phase     (ini_phase),
        .ren           (ren),
        .drop          (drop),
        .state_cheak   (state_cheak),
        .busy          (busy),
        .converged     (converged),
        .timeout       (timeout),
        .tick_count    (tick_count),
        .dbg_state     (dbg_state)
    );

    // Clock / watchdog
    always #5 sclk = ~sclk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] sc;
        int           busy_checks;
        int           exp_ticks;
        logic         exp_conv;
        logic         exp_tmo;
    } vec_t;

    vec_t rows[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    // Accept a start and check the whole LOAD walk against the scoreboard.
    task automatic do_start(input logic [N*PW-1:0] p);
        logic [N-1:0] r;
        logic [W-1:0] e;
        pattern = p;
        start   = 1'b1;
        for (int k = 0; k < N; k++) begin
            r = '0;
            r[k] = 1'b1;
            exp_q.push_back({r, p[k*PW +: PW]});
        end
        step();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == 6) pattern = ~p;
            e = exp_q.pop_front();
            check("load_drop", 32'(drop), 32'd1);
            check("load_ren_phase", 32'({ren, ini_phase}), 32'(e));
            check("load_busy", 32'(busy), 32'd1);
            if (k == 0) begin
                check("start_clr_conv", 32'(converged), 32'd0);
                check("start_clr_tmo", 32'(timeout), 32'd0);
                check("start_clr_ticks", 32'(tick_count), 32'd0);
            end
            step();
        end
        check("post_load_drop", 32'(drop), 32'd0);
        check("post_load_ren", 32'(ren), 32'd0);
        check("post_load_busy", 32'(busy), 32'd1);
        check("post_load_cheak", 32'(state_cheak), 32'd0);
    endtask

    // Run checks until a decision; state_changed = v.sc for the first
    // v.busy_checks checks and zero afterwards.
    task automatic run_row(input vec_t v, input int id);
        int  m_stable;
        int  m_ticks;
        bit  done;
        int  gap;
        m_stable = 0;
        m_ticks  = 0;
        done     = 1'b0;
        for (int c = 1; c <= 300 && !done; c++) begin
            gap = $urandom_range(1, 6);
            repeat (gap) step();
            full_tick = 1'b1;
            step();
            full_tick = 1'b0;
            m_ticks++;
            check("check_strobe_hi", 32'(state_cheak), 32'd1);
            check("tick_count_run", 32'(tick_count), 32'(m_ticks));
            state_changed = (c <= v.busy_checks) ? v.sc : '0;
            step();
            check("check_strobe_lo", 32'(state_cheak), 32'd0);
            step();
            m_stable = (state_changed != '0) ? 0 : m_stable + 1;
            done = (m_stable == 4) || (m_ticks >= 200);
            check("busy_after_sample", 32'(busy), done ? 32'd0 : 32'd1);
        end
        if (!done) check("run_budget", 32'd0, 32'd1);
        check($sformatf("row%0d_ticks", id), 32'(tick_count), 32'(v.exp_ticks));
        check($sformatf("row%0d_conv", id), 32'(converged), 32'(v.exp_conv));
        check($sformatf("row%0d_tmo", id), 32'(timeout), 32'(v.exp_tmo));
        state_changed = '0;
    endtask

    function automatic logic [N*PW-1:0] rand_pattern();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[N*PW-1:0];
    endfunction

    initial begin
        logic [N*PW-1:0] pk;
        logic [N*PW-1:0] p;

        rows[0] = '{sc: 15'h0000, busy_checks: 0,    exp_ticks: 4,   exp_conv: 1'b1, exp_tmo: 1'b0};
        rows[1] = '{sc: 15'h7FFF, busy_checks: 3,    exp_ticks: 7,   exp_conv: 1'b1, exp_tmo: 1'b0};
        rows[2] = '{sc: 15'h4000, busy_checks: 1,    exp_ticks: 5,   exp_conv: 1'b1, exp_tmo: 1'b0};
        rows[3] = '{sc: 15'h0001, busy_checks: 1000, exp_ticks: 200, exp_conv: 1'b0, exp_tmo: 1'b1};
        rows[4] = '{sc: 15'h0100, busy_checks: 196,  exp_ticks: 200, exp_conv: 1'b1, exp_tmo: 1'b0};
        rows[5] = '{sc: 15'h0010, busy_checks: 197,  exp_ticks: 200, exp_conv: 1'b0, exp_tmo: 1'b1};

        for (int k = 0; k < N; k++) pk[k*PW +: PW] = PW'(k);

        // Reset state
        re_n = 1'b0;
        repeat (3) step();
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_ren", 32'(ren), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({converged, timeout, state_cheak}), 32'd0);
        check("rst_ticks", 32'(tick_count), 32'd0);
        check("rst_phase", 32'(ini_phase), 32'd0);
        re_n = 1'b1;
        step();
        check("idle_no_drop", 32'(drop), 32'd0);

        // Table of run scenarios, each with a fresh start
        for (int r = 0; r < 6; r++) begin
            p = (r == 0) ? pk : rand_pattern();
            do_start(p);
            run_row(rows[r], r);
        end

        // DONE holds outputs
        repeat (3) step();
        check("done_hold_tmo", 32'(timeout), 32'd1);
        check("done_hold_conv", 32'(converged), 32'd0);
        check("done_hold_busy", 32'(busy), 32'd0);
        check("done_hold_drop", 32'(drop), 32'd0);

        // full_tick held high: ignored during LOAD, accepted every 3 cycles in RUN;
        // start held high while busy is ignored.
        full_tick = 1'b1;
        do_start(rand_pattern());
        check("held_load_ticks_ignored", 32'(tick_count), 32'd0);
        start   = 1'b1;
        pattern = rand_pattern();
        for (int j = 1; j <= 12; j++) begin
            step();
            check("held_cheak", 32'(state_cheak), (j % 3 == 1) ? 32'd1 : 32'd0);
            check("held_ticks", 32'(tick_count), 32'((j + 2) / 3));
            check("held_no_drop", 32'(drop), 32'd0);
            if (j < 12) check("held_busy", 32'(busy), 32'd1);
        end
        start     = 1'b0;
        full_tick = 1'b0;
        check("held_conv", 32'(converged), 32'd1);
        check("held_done_busy", 32'(busy), 32'd0);

        // Reset asserted at LOAD index 7
        pattern = rand_pattern();
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("pre_rst_ren", 32'(ren), 32'h0080);
        #2;
        re_n = 1'b0;
        #1;
        check("async_rst_drop", 32'(drop), 32'd0);
        check("async_rst_ren", 32'(ren), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_conv", 32'(converged), 32'd0);
        step();
        re_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            check("post_rst_no_drop", 32'(drop), 32'd0);
            check("post_rst_idle", 32'(dbg_state), 32'd0);
        end

        // Recovery after reset
        do_start(rand_pattern());
        run_row(rows[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/onn_phase_loader.md
Name: onn_phase_loader

Overview:
- Initialisation and convergence controller for the 3x5 ONN neuron array.
- Writes a captured initial-phase pattern into the per-neuron phase registers one neuron per cycle, using the ren/drop/ini_phase write interface.
- Then runs the network, strobing state_cheak after every full_tick and reading back the neurons' state_changed flags.
- Declares convergence or timeout. Sits between the host/pattern source and the neuron array.

Parameters:
- N, 15, number of neurons (3x5 array).
- PW, 4, phase width in bits.
- STABLE_TICKS, 4, consecutive no-change checks required to declare convergence.
- MAX_TICKS, 200, accepted full_ticks before timeout.
- TW, 8, tick counter width; MAX_TICKS < 2^TW.

Ports:
- sclk  in  1  system clock, all logic on rising edge.
- re_n  in  1  reset, asynchronous, active-low.
- start  in  1  level; accepted only in IDLE or DONE.
- pattern  in  N*PW  initial phases; neuron k = pattern[k*PW+PW-1:k*PW].
- full_tick  in  1  one-cycle pulse, end of one oscillation period.
- state_changed  in  N  per-neuron phase-changed flags.
- ini_phase  out  PW  shared initial-phase bus to all neurons.
- ren  out  N  one-hot per-neuron write enable.
- drop  out  1  write strobe; a neuron loads when ren[k] & drop.
- state_cheak  out  1  one-cycle check strobe to all neurons.
- busy  out  1  high in LOAD, RUN, CHECK, SAMPLE.
- converged  out  1  sticky until next accepted start or reset.
- timeout  out  1  sticky until next accepted start or reset.
- tick_count  out  TW  accepted full_ticks since last start.

Behaviour:

Reset (re_n=0, async):
- State = IDLE. All outputs 0, index = 0, stable count = 0, pattern shadow = 0.
- Reset mid-LOAD or mid-RUN aborts immediately. No partial write continues after release.

IDLE / DONE:
- start=1 at an edge: capture pattern into the shadow; clear converged, timeout, tick_count and stable count; index=0; go to LOAD.
- Later pattern changes have no effect on the run in progress.

LOAD (exactly N cycles, index 0..N-1):
- ren = one-hot(index), drop=1, ini_phase = shadow slice[index].
- After index N-1: ren=0, drop=0, go to RUN.
- ren and drop are never high outside LOAD.

RUN:
- Wait for full_tick.
- On full_tick: tick_count+1 (saturating at 2^TW-1), go to CHECK.

CHECK (1 cycle):
- state_cheak=1, go to SAMPLE.

SAMPLE (1 cycle):
- state_cheak=0; evaluate OR of state_changed.
- OR=1: stable count = 0.
- OR=0: stable count + 1.
- If the new stable count == STABLE_TICKS: converged=1, go to DONE.
- Else if tick_count >= MAX_TICKS: timeout=1, go to DONE.
- Else go to RUN.
- If both conditions hold in the same SAMPLE, convergence wins; timeout stays 0.

Ignored inputs:
- full_tick pulses arriving in LOAD, CHECK or SAMPLE are dropped and not counted.
- start in LOAD/RUN/CHECK/SAMPLE is ignored.

DONE:
- Outputs hold.
- busy=0, exactly one of converged/timeout is 1.
- start re-launches with a fresh capture.

General:
- Latency start-accept to first drop: 1 cycle.
- Latency full_tick to state_cheak: 1 cycle.
- Latency state_cheak to decision: 1 cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then start=1 with pattern neuron k = k mod 16 -> 15 consecutive cycles of drop=1; ren walks 0x0001..0x4000; ini_phase = 0,1,..,14; then ren=0, drop=0, busy stays 1.
- Mid-LOAD pattern change -> remaining ini_phase values still come from the captured pattern.
- state_changed=0 at every check, full_tick every 16 cycles -> converged=1 right after the 4th SAMPLE; tick_count=4; timeout=0; busy=0.
- state_changed nonzero on checks 1-3, zero from check 4 on -> converged after check 7; tick_count=7.
- state_changed=0x0001 always, MAX_TICKS=200 -> timeout=1 after the 200th SAMPLE; converged=0; tick_count=200.
- full_tick held high continuously -> ticks accepted only in RUN, one every 3 cycles; state_cheak pulses exactly 1 cycle each.
- re_n low at LOAD index 7 -> all outputs 0 immediately (async); after release, state is IDLE and no drop occurs until a new start.
